// File: rtl/io_seg_display.sv
// Samples three output-port words and shows each as three decimal digits
// on active-low 7-segment registers, using one shared double-dabble engine.
module io_seg_display #(
   parameter int DATA_W   = 8,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] port0,
   input  logic [31:0] port1,
   input  logic [31:0] port2,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6,
   output logic [6:0]  hex7,
   output logic [6:0]  hex8,
   output logic        busy,
   output logic        done,
   output logic [1:0]  done_port
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_COMMIT
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_idx;
   logic [1:0]        w_idx_inc;
   logic [DATA_W-1:0] r_shadow [3];
   logic [DATA_W-1:0] r_snap;
   logic [DATA_W-1:0] r_bin;
   logic [11:0]       r_bcd;
   logic [3:0]        r_cnt;
   logic [6:0]        r_hex [9];
   logic              r_busy;
   logic              r_done;
   logic [1:0]        r_done_port;
   logic [DATA_W-1:0] w_cur;
   logic [DATA_W-1:0] w_cur_shadow;
   logic [11:0]       w_adj;
   logic [6:0]        w_seg [3];
   logic              w_unused;

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    f_seg = 7'b1000000;
         4'd1:    f_seg = 7'b1111001;
         4'd2:    f_seg = 7'b0100100;
         4'd3:    f_seg = 7'b0110000;
         4'd4:    f_seg = 7'b0011001;
         4'd5:    f_seg = 7'b0010010;
         4'd6:    f_seg = 7'b0000010;
         4'd7:    f_seg = 7'b1111000;
         4'd8:    f_seg = 7'b0000000;
         4'd9:    f_seg = 7'b0010000;
         default: f_seg = SEG_BLANK;
      endcase
   endfunction

   assign w_unused = ^{port0[31:DATA_W], port1[31:DATA_W], port2[31:DATA_W]};

   assign w_idx_inc = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;

   always_comb begin
      w_cur        = port0[DATA_W-1:0];
      w_cur_shadow = r_shadow[0];
      case (r_idx)
         2'd1: begin
            w_cur        = port1[DATA_W-1:0];
            w_cur_shadow = r_shadow[1];
         end
         2'd2: begin
            w_cur        = port2[DATA_W-1:0];
            w_cur_shadow = r_shadow[2];
         end
         default: ;
      endcase
   end

   // add-3 correction applied before each shift
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 3; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_seg[0] = f_seg(r_bcd[3:0]);
      w_seg[1] = (BLANK_LZ && r_bcd[11:4] == 8'd0) ? SEG_BLANK
                                                    : f_seg(r_bcd[7:4]);
      w_seg[2] = (BLANK_LZ && r_bcd[11:8] == 4'd0) ? SEG_BLANK
                                                    : f_seg(r_bcd[11:8]);
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (w_cur != w_cur_shadow) w_state_nxt = S_LOAD;
         S_LOAD:   w_state_nxt = S_SHIFT;
         S_SHIFT:  if (r_cnt == 4'd1) w_state_nxt = S_COMMIT;
         S_COMMIT: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_idx       <= 2'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_done_port <= 2'd0;
         r_snap      <= '0;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_cnt       <= 4'd0;
         for (int k = 0; k < 3; k++)
            r_shadow[k] <= '0;
         for (int j = 0; j < 9; j++)
            r_hex[j] <= (j % 3 == 0 || !BLANK_LZ) ? SEG_ZERO : SEG_BLANK;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= (w_state_nxt == S_COMMIT);
         if (w_state_nxt == S_COMMIT)
            r_done_port <= r_idx;
         unique case (r_state)
            S_IDLE: begin
               if (w_state_nxt == S_IDLE)
                  r_idx <= w_idx_inc;
            end
            S_LOAD: begin
               r_snap <= w_cur;
               r_bin  <= w_cur;
               r_bcd  <= '0;
               r_cnt  <= 4'(DATA_W);
            end
            S_SHIFT: begin
               r_bcd <= {w_adj[10:0], r_bin[DATA_W-1]};
               r_bin <= {r_bin[DATA_W-2:0], 1'b0};
               r_cnt <= r_cnt - 4'd1;
            end
            S_COMMIT: begin
               for (int k = 0; k < 3; k++) begin
                  if (r_idx == 2'(k)) begin
                     r_shadow[k] <= r_snap;
                     for (int j = 0; j < 3; j++)
                        r_hex[3*k+j] <= w_seg[j];
                  end
               end
               r_idx <= w_idx_inc;
            end
         endcase
      end
   end

   assign hex0      = r_hex[0];
   assign hex1      = r_hex[1];
   assign hex2      = r_hex[2];
   assign hex3      = r_hex[3];
   assign hex4      = r_hex[4];
   assign hex5      = r_hex[5];
   assign hex6      = r_hex[6];
   assign hex7      = r_hex[7];
   assign hex8      = r_hex[8];
   assign busy      = r_busy;
   assign done      = r_done;
   assign done_port = r_done_port;

endmodule

// File: tb/tb_io_seg_display.sv
// Self-checking bench for io_seg_display: decimal/segment model vs DUT,
// with a second instance built without leading-zero blanking.
module tb_io_seg_display;

   localparam int         DW   = 8;
   localparam logic [6:0] BL   = 7'b1111111;
   localparam logic [6:0] ZERO = 7'b1000000;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] port_w [3];

   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, hex8;
   logic       busy, done;
   logic [1:0] done_port;
   logic [6:0] nhex0, nhex1, nhex2, nhex3, nhex4, nhex5, nhex6, nhex7, nhex8;
   logic       nbusy, ndone;
   logic [1:0] ndone_port;

   int checks   = 0;
   int failures = 0;
   int sh [3];

   logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};

   always #5 clock = ~clock;

   io_seg_display #(.DATA_W(DW), .BLANK_LZ(1'b1)) u_dut (
      .clock(clock), .resetn(resetn),
      .port0(port_w[0]), .port1(port_w[1]), .port2(port_w[2]),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
      .hex5(hex5), .hex6(hex6), .hex7(hex7), .hex8(hex8),
      .busy(busy), .done(done), .done_port(done_port)
   );

   io_seg_display #(.DATA_W(DW), .BLANK_LZ(1'b0)) u_dut_nb (
      .clock(clock), .resetn(resetn),
      .port0(port_w[0]), .port1(port_w[1]), .port2(port_w[2]),
      .hex0(nhex0), .hex1(nhex1), .hex2(nhex2), .hex3(nhex3), .hex4(nhex4),
      .hex5(nhex5), .hex6(nhex6), .hex7(nhex7), .hex8(nhex8),
      .busy(nbusy), .done(ndone), .done_port(ndone_port)
   );

   // expected {hundreds, tens, ones} segments from plain decimal arithmetic
   function automatic logic [20:0] exp_hex(input int v, input bit blz);
      logic [6:0] h0, h1, h2;
      h0 = SEG[v % 10];
      h1 = (blz && v < 10)  ? BL : SEG[(v / 10) % 10];
      h2 = (blz && v < 100) ? BL : SEG[v / 100];
      return {h2, h1, h0};
   endfunction

   function automatic logic [20:0] dut_hex(input int k);
      case (k)
         0:       return {hex2, hex1, hex0};
         1:       return {hex5, hex4, hex3};
         default: return {hex8, hex7, hex6};
      endcase
   endfunction

   function automatic logic [20:0] nb_hex(input int k);
      case (k)
         0:       return {nhex2, nhex1, nhex0};
         1:       return {nhex5, nhex4, nhex3};
         default: return {nhex8, nhex7, nhex6};
      endcase
   endfunction

   task automatic wait_done(input int bound, output bit got, output int p);
      got = 1'b0;
      p   = -1;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            got = 1'b1;
            p   = int'(done_port);
         end
      end
   endtask

   task automatic wait_busy(input int bound, output bit got);
      got = 1'b0;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clock);
         if (busy === 1'b1) got = 1'b1;
      end
   endtask

   task automatic drive_and_wait(input int k, input logic [31:0] v,
                                 output bit got, output int p);
      port_w[k] = v;
      wait_done(40, got, p);
      @(negedge clock);
   endtask

   task automatic test_reset;
      bit got;
      int p;
      for (int k = 0; k < 3; k++) port_w[k] = 32'h12345678;
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (hex0 !== ZERO) begin
         failures++;
         $display("FAIL reset_hex0: got %b want %b", hex0, ZERO);
      end
      checks++;
      if (hex1 !== BL || hex2 !== BL) begin
         failures++;
         $display("FAIL reset_hex12: got %b %b want %b", hex1, hex2, BL);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || done_port !== 2'd0) begin
         failures++;
         $display("FAIL reset_ctl: got busy=%b done=%b port=%0d want 0 0 0",
                  busy, done, done_port);
      end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (dut_hex(j) !== exp_hex(0, 1'b1) || nb_hex(j) !== exp_hex(0, 1'b0)) begin
            failures++;
            $display("FAIL reset_port%0d: got %h/%h want %h/%h", j, dut_hex(j),
                     nb_hex(j), exp_hex(0, 1'b1), exp_hex(0, 1'b0));
         end
         sh[j] = 0;
      end
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_done(40, got, p);
         checks++;
         if (!got || p != k) begin
            failures++;
            $display("FAIL reset_order: got port %0d (seen=%0b) want %0d", p, got, k);
         end
         sh[k] = 'h78;
      end
      @(negedge clock);
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (dut_hex(j) !== exp_hex(sh[j], 1'b1) || nb_hex(j) !== exp_hex(sh[j], 1'b0)) begin
            failures++;
            $display("FAIL reset_conv%0d: got %h/%h want %h/%h", j, dut_hex(j),
                     nb_hex(j), exp_hex(sh[j], 1'b1), exp_hex(sh[j], 1'b0));
         end
      end
   endtask

   task automatic test_single;
      bit got;
      bit bad;
      int n;
      port_w[0] = 32'h000000FF;
      wait_busy(10, got);
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL single_busy_rise: got busy=%b want 1", busy);
      end
      n   = 1;
      bad = 1'b0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
         if (busy !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (n != 10 || done_port !== 2'd0 || bad) begin
         failures++;
         $display("FAIL single_latency: got cycles=%0d port=%0d busy_drop=%0b want 10 0 0",
                  n, done_port, bad);
      end
      sh[0] = 255;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || {hex2, hex1, hex0} !== {7'b0100100, 7'b0010010, 7'b0010010}) begin
         failures++;
         $display("FAIL single_255: got busy=%b hex=%b %b %b want 0 0100100 0010010 0010010",
                  busy, hex2, hex1, hex0);
      end
      port_w[0] = 32'hFFFFFFFF;
      bad = 1'b0;
      repeat (15) begin
         @(negedge clock);
         if (busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL upper_bits: got busy=1 want no reconversion");
      end
   endtask

   task automatic test_leading_zero;
      bit got;
      int p;
      drive_and_wait(1, 32'd7, got, p);
      sh[1] = 7;
      checks++;
      if (!got || p != 1) begin
         failures++;
         $display("FAIL lz_done: got port %0d want 1", p);
      end
      checks++;
      if ({hex5, hex4, hex3} !== {BL, BL, 7'b1111000}) begin
         failures++;
         $display("FAIL lz_blank: got %b %b %b want 1111111 1111111 1111000",
                  hex5, hex4, hex3);
      end
      checks++;
      if ({nhex5, nhex4, nhex3} !== {ZERO, ZERO, 7'b1111000}) begin
         failures++;
         $display("FAIL lz_noblank: got %b %b %b want 1000000 1000000 1111000",
                  nhex5, nhex4, nhex3);
      end
   endtask

   task automatic test_boundaries;
      bit got;
      int p;
      int vals [5] = '{9, 10, 99, 100, 0};
      foreach (vals[i]) begin
         drive_and_wait(2, 32'(vals[i]), got, p);
         sh[2] = vals[i];
         checks++;
         if (!got || p != 2) begin
            failures++;
            $display("FAIL bound_done_%0d: got port %0d want 2", vals[i], p);
         end
         checks++;
         if (dut_hex(2) !== exp_hex(vals[i], 1'b1) || nb_hex(2) !== exp_hex(vals[i], 1'b0)) begin
            failures++;
            $display("FAIL bound_%0d: got %h/%h want %h/%h", vals[i], dut_hex(2),
                     nb_hex(2), exp_hex(vals[i], 1'b1), exp_hex(vals[i], 1'b0));
         end
      end
   endtask

   task automatic test_mid_change;
      bit got;
      int p;
      logic [41:0] snap;
      port_w[0] = 32'd3;
      wait_busy(10, got);
      repeat (2) @(negedge clock);
      port_w[0] = 32'd200;
      snap = {hex8, hex7, hex6, hex5, hex4, hex3};
      wait_done(40, got, p);
      @(negedge clock);
      checks++;
      if (!got || p != 0 || dut_hex(0) !== exp_hex(3, 1'b1)) begin
         failures++;
         $display("FAIL mid_snapshot: got port %0d hex %h want 0 %h", p,
                  dut_hex(0), exp_hex(3, 1'b1));
      end
      wait_done(40, got, p);
      @(negedge clock);
      sh[0] = 200;
      checks++;
      if (!got || p != 0 || dut_hex(0) !== exp_hex(200, 1'b1) ||
          nb_hex(0) !== exp_hex(200, 1'b0)) begin
         failures++;
         $display("FAIL mid_recon: got port %0d hex %h want 0 %h", p,
                  dut_hex(0), exp_hex(200, 1'b1));
      end
      checks++;
      if ({hex8, hex7, hex6, hex5, hex4, hex3} !== snap) begin
         failures++;
         $display("FAIL mid_others: got %h want %h",
                  {hex8, hex7, hex6, hex5, hex4, hex3}, snap);
      end
   endtask

   task automatic test_mid_reset;
      bit got;
      int p;
      port_w[1] = 32'd77;
      wait_busy(10, got);
      repeat (3) @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || done_port !== 2'd0) begin
         failures++;
         $display("FAIL midrst_ctl: got busy=%b done=%b port=%0d want 0 0 0",
                  busy, done, done_port);
      end
      for (int j = 0; j < 3; j++) begin
         sh[j] = 0;
         checks++;
         if (dut_hex(j) !== exp_hex(0, 1'b1) || nb_hex(j) !== exp_hex(0, 1'b0)) begin
            failures++;
            $display("FAIL midrst_hex%0d: got %h/%h want %h/%h", j, dut_hex(j),
                     nb_hex(j), exp_hex(0, 1'b1), exp_hex(0, 1'b0));
         end
      end
      resetn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_done(40, got, p);
         checks++;
         if (!got || p != k) begin
            failures++;
            $display("FAIL midrst_order: got port %0d want %0d", p, k);
         end
      end
      sh[0] = 200;
      sh[1] = 77;
      @(negedge clock);
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (dut_hex(j) !== exp_hex(sh[j], 1'b1)) begin
            failures++;
            $display("FAIL midrst_conv%0d: got %h want %h", j, dut_hex(j),
                     exp_hex(sh[j], 1'b1));
         end
      end
   endtask

   task automatic test_simultaneous;
      bit got;
      int p;
      int t;
      int n;
      int order [3];
      drive_and_wait(2, 32'd50, got, p);
      sh[2] = 50;
      checks++;
      if (!got || p != 2) begin
         failures++;
         $display("FAIL simul_prep: got port %0d want 2", p);
      end
      for (int k = 0; k < 3; k++) begin
         port_w[k] = 32'(k + 1);
         sh[k]     = k + 1;
         order[k]  = -1;
      end
      t = 0;
      n = 0;
      while (n < 3 && t < 40) begin
         @(negedge clock);
         t++;
         if (done === 1'b1) begin
            order[n] = int'(done_port);
            n++;
         end
      end
      @(negedge clock);
      t++;
      checks++;
      if (n != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
         failures++;
         $display("FAIL simul_order: got n=%0d %0d,%0d,%0d want 3 0,1,2",
                  n, order[0], order[1], order[2]);
      end
      checks++;
      if (t > 33) begin
         failures++;
         $display("FAIL simul_latency: got %0d cycles want <= 33", t);
      end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (dut_hex(j) !== exp_hex(sh[j], 1'b1) || nb_hex(j) !== exp_hex(sh[j], 1'b0)) begin
            failures++;
            $display("FAIL simul_hex%0d: got %h/%h want %h/%h", j, dut_hex(j),
                     nb_hex(j), exp_hex(sh[j], 1'b1), exp_hex(sh[j], 1'b0));
         end
      end
   endtask

   task automatic test_random;
      bit          got;
      int          p;
      int          k;
      logic [31:0] v;
      for (int it = 0; it < 24; it++) begin
         k = int'($urandom_range(2, 0));
         v = $urandom;
         while (int'(v[DW-1:0]) == sh[k]) v = $urandom;
         drive_and_wait(k, v, got, p);
         sh[k] = int'(v[DW-1:0]);
         checks++;
         if (!got || p != k) begin
            failures++;
            $display("FAIL rand_done_%0d: got port %0d want %0d", it, p, k);
         end
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (dut_hex(j) !== exp_hex(sh[j], 1'b1) || nb_hex(j) !== exp_hex(sh[j], 1'b0)) begin
               failures++;
               $display("FAIL rand_hex_%0d_%0d: got %h/%h want %h/%h", it, j,
                        dut_hex(j), nb_hex(j), exp_hex(sh[j], 1'b1),
                        exp_hex(sh[j], 1'b0));
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_leading_zero;
      test_boundaries;
      test_mid_change;
      test_mid_reset;
      test_simultaneous;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
